// File: rtl/uart_tx_frame.sv
// UART transmitter: 1-word holding buffer, internal baud divider, runtime parity (none/even/odd), 1 or 2 stop bits.
// Queued words follow the previous stop bit with no idle gap.
module uart_tx_frame #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  uart_clk,
  input  logic                  rst,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] tx_in,
  input  logic [1:0]            parity_mode,
  output logic                  tx_out,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = $clog2(DATA_WIDTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  generate
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
      $error("uart_tx_frame: DATA_WIDTH must be 5..9");
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
      $error("uart_tx_frame: CLKS_PER_BIT must be >= 1");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d, input logic [1:0] mode);
    return (^d) ^ (mode == 2'b10);
  endfunction

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == 2'b01) || (mode == 2'b10);
  endfunction

  state_t                  state, state_n;
  logic [BAUD_W-1:0]       baud_cnt, baud_n;
  logic [IDX_W-1:0]        bit_idx, bit_n;
  logic                    stop_cnt, stop_n;
  logic                    hold_full;
  logic [DATA_WIDTH-1:0]   hold_data;
  logic [1:0]              hold_mode;
  logic [DATA_WIDTH-1:0]   shift, shift_n;
  logic                    par_bit, par_n;
  logic                    par_en, pen_n;
  logic                    load, accept, baud_last, out_n, done_n;

  assign tx_ready  = ~hold_full;
  assign accept    = tx_valid & ~hold_full;
  assign baud_last = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    stop_n  = stop_cnt;
    shift_n = shift;
    par_n   = par_bit;
    pen_n   = par_en;
    load    = 1'b0;
    unique case (state)
      IDLE: load = hold_full;
      START: begin
        baud_n = baud_last ? '0 : baud_cnt + BAUD_W'(1);
        if (baud_last) begin
          state_n = DATA;
          bit_n   = '0;
        end
      end
      DATA: begin
        baud_n = baud_last ? '0 : baud_cnt + BAUD_W'(1);
        if (baud_last) begin
          shift_n = shift >> 1;
          if (bit_idx == IDX_LAST) begin
            bit_n   = '0;
            stop_n  = 1'b0;
            state_n = par_en ? PARITY : STOP;
          end else begin
            bit_n = bit_idx + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        baud_n = baud_last ? '0 : baud_cnt + BAUD_W'(1);
        if (baud_last) begin
          state_n = STOP;
          stop_n  = 1'b0;
        end
      end
      STOP: begin
        baud_n = baud_last ? '0 : baud_cnt + BAUD_W'(1);
        if (baud_last) begin
          if (stop_cnt == STOP_LAST) begin
            stop_n  = 1'b0;
            state_n = IDLE;
            load    = hold_full;
          end else begin
            stop_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // A load overrides the STOP->IDLE exit so the next start bit follows directly.
    if (load) begin
      state_n = START;
      baud_n  = '0;
      bit_n   = '0;
      stop_n  = 1'b0;
      shift_n = hold_data;
      par_n   = parity_of(hold_data, hold_mode);
      pen_n   = parity_enabled(hold_mode);
    end

    unique case (state_n)
      START:   out_n = 1'b0;
      DATA:    out_n = shift_n[0];
      PARITY:  out_n = par_n;
      default: out_n = 1'b1;
    endcase
    done_n = (state_n == STOP) && (baud_n == BAUD_LAST) && (stop_n == STOP_LAST);
  end

  always_ff @(posedge uart_clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
      hold_full <= 1'b0;
      tx_out    <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_idx   <= bit_n;
      stop_cnt  <= stop_n;
      hold_full <= load ? 1'b0 : (accept ? 1'b1 : hold_full);
      tx_out    <= out_n;
      tx_busy   <= (state_n != IDLE);
      tx_done   <= done_n;
    end
  end

  // Datapath registers carry no reset; hold_full and the FSM gate their use.
  always_ff @(posedge uart_clk) begin
    if (accept) begin
      hold_data <= tx_in;
      hold_mode <= parity_mode;
    end
    shift   <= shift_n;
    par_bit <= par_n;
    par_en  <= pen_n;
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: instance A (8 bits, 4 clks/bit, 1 stop) and
// instance B (7 bits, 1 clk/bit, 2 stop), checked cycle by cycle against hand-built frames.
module tb_uart_tx_frame;

  logic uart_clk = 1'b0;
  always #5 uart_clk = ~uart_clk;

  logic       rst_a = 1'b1, a_valid = 1'b0, a_ready, a_out, a_busy, a_done;
  logic [7:0] a_in = '0;
  logic [1:0] a_mode = '0;
  logic       rst_b = 1'b1, b_valid = 1'b0, b_ready, b_out, b_busy, b_done;
  logic [6:0] b_in = '0;
  logic [1:0] b_mode = '0;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
    .uart_clk(uart_clk), .rst(rst_a), .tx_valid(a_valid), .tx_ready(a_ready),
    .tx_in(a_in), .parity_mode(a_mode), .tx_out(a_out), .tx_busy(a_busy), .tx_done(a_done));

  uart_tx_frame #(.DATA_WIDTH(7), .CLKS_PER_BIT(1), .STOP_BITS(2)) dut_b (
    .uart_clk(uart_clk), .rst(rst_b), .tx_valid(b_valid), .tx_ready(b_ready),
    .tx_in(b_in), .parity_mode(b_mode), .tx_out(b_out), .tx_busy(b_busy), .tx_done(b_done));

  function automatic logic o_of(input bit sel);  return sel ? b_out   : a_out;   endfunction
  function automatic logic r_of(input bit sel);  return sel ? b_ready : a_ready; endfunction
  function automatic logic bz_of(input bit sel); return sel ? b_busy  : a_busy;  endfunction
  function automatic logic d_of(input bit sel);  return sel ? b_done  : a_done;  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge uart_clk);
    #1;
  endtask

  // Offers one word, lets it be accepted on the next edge, then releases tx_valid.
  task automatic send(input bit sel, input logic [7:0] d, input logic [1:0] m);
    if (sel) begin b_valid = 1'b1; b_in = d[6:0]; b_mode = m; end
    else     begin a_valid = 1'b1; a_in = d;      a_mode = m; end
    chk("ready_before_accept", 16'(r_of(sel)), 16'd1);
    step();
    if (sel) b_valid = 1'b0; else a_valid = 1'b0;
    chk("ready_after_accept", 16'(r_of(sel)), 16'd0);
    chk("out_before_start", 16'(o_of(sel)), 16'd1);
  endtask

  // bits[i] is the i-th transmitted bit; checks cycles first_k..nbits*cpb of the frame.
  task automatic frame(input string tag, input bit sel, input int nbits, input logic [15:0] bits,
                       input int cpb, input int first_k);
    int tot;
    tot = nbits * cpb;
    for (int k = first_k; k <= tot; k++) begin
      step();
      chk($sformatf("%s_out_c%0d", tag, k), 16'(o_of(sel)), 16'(bits[(k-1)/cpb]));
      chk($sformatf("%s_done_c%0d", tag, k), 16'(d_of(sel)), 16'(k == tot));
      chk($sformatf("%s_busy_c%0d", tag, k), 16'(bz_of(sel)), 16'd1);
    end
  endtask

  task automatic idle(input string tag, input bit sel, input int n);
    for (int k = 0; k < n; k++) begin
      step();
      chk({tag, "_out"},   16'(o_of(sel)), 16'd1);
      chk({tag, "_busy"},  16'(bz_of(sel)), 16'd0);
      chk({tag, "_done"},  16'(d_of(sel)), 16'd0);
      chk({tag, "_ready"}, 16'(r_of(sel)), 16'd1);
    end
  endtask

  initial begin
    // Reset with tx_valid asserted: nothing may be accepted.
    a_valid = 1'b1; a_in = 8'hFF; b_valid = 1'b1; b_in = 7'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_a_out", 16'(a_out), 16'd1);
      chk("rst_a_ready", 16'(a_ready), 16'd1);
      chk("rst_a_busy", 16'(a_busy), 16'd0);
      chk("rst_a_done", 16'(a_done), 16'd0);
      chk("rst_b_out", 16'(b_out), 16'd1);
      chk("rst_b_ready", 16'(b_ready), 16'd1);
    end
    rst_a = 1'b0; rst_b = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    idle("post_rst_a", 1'b0, 4);
    idle("post_rst_b", 1'b1, 2);

    // 0xA5 even parity: start 0, data LSB first, parity 0, stop 1.
    send(1'b0, 8'hA5, 2'b01);
    frame("a5_even", 1'b0, 11, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 4, 1);
    idle("a5_after", 1'b0, 2);

    // 0x01 odd parity -> parity bit 0; 0x01 no parity -> 10-bit frame.
    send(1'b0, 8'h01, 2'b10);
    frame("01_odd", 1'b0, 11, {5'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 4, 1);
    idle("01_odd_after", 1'b0, 1);
    send(1'b0, 8'h01, 2'b00);
    frame("01_none", 1'b0, 10, {6'b0, 1'b1, 8'h01, 1'b0}, 4, 1);
    idle("01_none_after", 1'b0, 1);

    // Back-to-back 0x55 then 0x0F with tx_valid held high.
    a_valid = 1'b1; a_in = 8'h55; a_mode = 2'b01;
    chk("b2b_ready0", 16'(a_ready), 16'd1);
    step();
    chk("b2b_ready_e0", 16'(a_ready), 16'd0);
    a_in = 8'h0F;
    step();
    chk("b2b_out_c1", 16'(a_out), 16'd0);
    chk("b2b_ready_e1", 16'(a_ready), 16'd1);
    chk("b2b_busy_c1", 16'(a_busy), 16'd1);
    step();
    a_valid = 1'b0;
    chk("b2b_ready_e2", 16'(a_ready), 16'd0);
    chk("b2b_out_c2", 16'(a_out), 16'd0);
    frame("b2b_55", 1'b0, 11, {5'b0, 1'b1, 1'b0, 8'h55, 1'b0}, 4, 3);
    frame("b2b_0f", 1'b0, 11, {5'b0, 1'b1, 1'b0, 8'h0F, 1'b0}, 4, 1);
    idle("b2b_after", 1'b0, 2);

    // Instance B: 7 data bits, 1 clk/bit, 2 stop bits, 0x7F odd parity.
    send(1'b1, 8'h7F, 2'b10);
    frame("b_7f_odd", 1'b1, 11, {5'b0, 2'b11, 1'b0, 7'h7F, 1'b0}, 1, 1);
    idle("b_after", 1'b1, 2);

    // Reset during data bit 3 of 0x96 with 0xFF queued.
    send(1'b0, 8'h96, 2'b01);
    step();
    a_valid = 1'b1; a_in = 8'hFF; a_mode = 2'b00;
    step();
    a_valid = 1'b0;
    chk("mid_queued_ready", 16'(a_ready), 16'd0);
    for (int k = 3; k <= 18; k++) step();
    chk("mid_bit3_out", 16'(a_out), 16'd0);
    rst_a = 1'b1;
    step();
    chk("mid_rst_out", 16'(a_out), 16'd1);
    chk("mid_rst_ready", 16'(a_ready), 16'd1);
    chk("mid_rst_busy", 16'(a_busy), 16'd0);
    chk("mid_rst_done", 16'(a_done), 16'd0);
    step();
    rst_a = 1'b0;
    idle("mid_no_queued", 1'b0, 50);
    send(1'b0, 8'h3C, 2'b01);
    frame("3c_even", 1'b0, 11, {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 4, 1);
    idle("3c_after", 1'b0, 10);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
